// File: rtl/freelist_ckpt_ctrl.sv
// freelist_ckpt_ctrl
//   Multi-entry checkpoint controller for the free-list head pointer.
//   - Each dispatched branch gets a tag, which is the index of its checkpoint slot.
//     The slot holds the head pointer supplied with that branch.
//   - Correctly predicted branches retire in program order.
//   - A mispredict produces a one-cycle restore of the head pointer.
//     In the same cycle it produces a squash mask of the killed tags.
//   Optional feature: define FLCKPT_STATS_EN to add the saturating counters
//   stat_mispredicts and stat_full_stalls.
module freelist_ckpt_ctrl #(
  parameter int PTR_WIDTH = 8,
  parameter int NUM_CKPT  = 4,
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_dispatch_req,
  input  logic [PTR_WIDTH-1:0] br_head_ptr,
  output logic                 br_dispatch_gnt,
  output logic [TAG_WIDTH-1:0] br_tag,
  output logic                 ckpt_full,
  input  logic                 br_resolve_valid,
  input  logic [TAG_WIDTH-1:0] br_resolve_tag,
  input  logic                 br_resolve_mispredict,
  output logic                 restore_valid,
  output logic [PTR_WIDTH-1:0] restore_ptr,
  output logic [NUM_CKPT-1:0]  squash_mask,
  output logic [TAG_WIDTH:0]   ckpt_count
`ifdef FLCKPT_STATS_EN
  ,
  output logic [15:0]          stat_mispredicts,
  output logic [15:0]          stat_full_stalls
`endif
);

  localparam int CW = TAG_WIDTH + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_CKPT);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t               state_r;
  logic [NUM_CKPT-1:0]  valid_r;
  logic [NUM_CKPT-1:0]  resolved_r;
  logic [PTR_WIDTH-1:0] ptr_r [NUM_CKPT];
  logic [TAG_WIDTH-1:0] alloc_idx_r;
  logic [TAG_WIDTH-1:0] retire_idx_r;
  logic [CW-1:0]        count_r;

  logic                 misp_s;
  logic                 correct_s;
  logic                 gnt_s;
  logic                 retire_s;
  logic [NUM_CKPT-1:0]  squash_s;
  logic [TAG_WIDTH-1:0] tag_age_s;
  logic [TAG_WIDTH-1:0] entry_age_s [NUM_CKPT];
  logic [NUM_CKPT-1:0]  valid_next_s;
  logic [NUM_CKPT-1:0]  resolved_next_s;
  logic [TAG_WIDTH-1:0] alloc_idx_next_s;
  logic [TAG_WIDTH-1:0] retire_idx_next_s;
  logic [CW-1:0]        count_next_s;

  // Full and empty are told apart by the count, because alloc_idx == retire_idx in both cases.
  assign ckpt_full  = (count_r == FULL_COUNT);
  assign ckpt_count = count_r;
  assign br_tag     = alloc_idx_r;

  // A resolve only matters when it names a live checkpoint.
  // Stale or squashed tags are dropped.
  assign misp_s    = br_resolve_valid & br_resolve_mispredict & valid_r[br_resolve_tag];
  assign correct_s = br_resolve_valid & ~br_resolve_mispredict & valid_r[br_resolve_tag];

  // Dispatch is blocked by any mispredict on the port, even a stale one.
  // This keeps the grant path independent of the valid lookup.
  assign gnt_s = br_dispatch_req & ~ckpt_full & (state_r == ST_RUN) &
                 ~(br_resolve_valid & br_resolve_mispredict);
  assign br_dispatch_gnt = gnt_s;

  // Squash every live entry that is the same age as or younger than the mispredicted tag.
  // Ages are measured from the oldest entry, so wrapped ranges need no special case.
  always_comb begin
    tag_age_s = br_resolve_tag - retire_idx_r;
    squash_s  = {NUM_CKPT{1'b0}};
    for (int i = 0; i < NUM_CKPT; i++) begin
      entry_age_s[i] = TAG_WIDTH'(i) - retire_idx_r;
      if (misp_s && valid_r[i] && (entry_age_s[i] >= tag_age_s)) begin
        squash_s[i] = 1'b1;
      end else begin
        squash_s[i] = 1'b0;
      end
    end
  end

  // An oldest entry that is not being squashed retires once it is resolved.
  assign retire_s = valid_r[retire_idx_r] & resolved_r[retire_idx_r] & ~squash_s[retire_idx_r];

  // Next-state logic for each entry, both queue indices and the occupancy count.
  always_comb begin
    valid_next_s    = valid_r;
    resolved_next_s = resolved_r;
    count_next_s    = {CW{1'b0}};
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (squash_s[i]) begin
        valid_next_s[i]    = 1'b0;
        resolved_next_s[i] = 1'b0;
      end else if (retire_s && (retire_idx_r == TAG_WIDTH'(i))) begin
        valid_next_s[i]    = 1'b0;
        resolved_next_s[i] = 1'b0;
      end else if (gnt_s && (alloc_idx_r == TAG_WIDTH'(i))) begin
        valid_next_s[i]    = 1'b1;
        resolved_next_s[i] = 1'b0;
      end else if (correct_s && (br_resolve_tag == TAG_WIDTH'(i))) begin
        valid_next_s[i]    = valid_r[i];
        resolved_next_s[i] = 1'b1;
      end else begin
        valid_next_s[i]    = valid_r[i];
        resolved_next_s[i] = resolved_r[i];
      end
      count_next_s = count_next_s + CW'(valid_next_s[i]);
    end

    if (misp_s) begin
      alloc_idx_next_s = br_resolve_tag;
    end else if (gnt_s) begin
      alloc_idx_next_s = alloc_idx_r + TAG_WIDTH'(1);
    end else begin
      alloc_idx_next_s = alloc_idx_r;
    end

    if (retire_s) begin
      retire_idx_next_s = retire_idx_r + TAG_WIDTH'(1);
    end else begin
      retire_idx_next_s = retire_idx_r;
    end
  end

  // Checkpoint storage and queue pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r      <= {NUM_CKPT{1'b0}};
      resolved_r   <= {NUM_CKPT{1'b0}};
      alloc_idx_r  <= {TAG_WIDTH{1'b0}};
      retire_idx_r <= {TAG_WIDTH{1'b0}};
      count_r      <= {CW{1'b0}};
      for (int i = 0; i < NUM_CKPT; i++) begin
        ptr_r[i] <= {PTR_WIDTH{1'b0}};
      end
    end else begin
      valid_r      <= valid_next_s;
      resolved_r   <= resolved_next_s;
      alloc_idx_r  <= alloc_idx_next_s;
      retire_idx_r <= retire_idx_next_s;
      count_r      <= count_next_s;
      if (gnt_s) begin
        ptr_r[alloc_idx_r] <= br_head_ptr;
      end
    end
  end

  // Recovery FSM.
  // Each accepted mispredict causes one RECOVER cycle.
  // The restore outputs are registered together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RUN;
      restore_valid <= 1'b0;
      restore_ptr   <= {PTR_WIDTH{1'b0}};
      squash_mask   <= {NUM_CKPT{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (misp_s) state_r <= ST_RECOVER;
          else        state_r <= ST_RUN;
        end
        ST_RECOVER: begin
          // An older live branch that mispredicts here overrides the restore in progress.
          if (misp_s) state_r <= ST_RECOVER;
          else        state_r <= ST_RUN;
        end
        default: state_r <= ST_RUN;
      endcase
      restore_valid <= misp_s;
      if (misp_s) begin
        restore_ptr <= ptr_r[br_resolve_tag];
        squash_mask <= squash_s;
      end
    end
  end

`ifdef FLCKPT_STATS_EN
  // Saturating event counters for accepted mispredicts and for dispatch stalls caused by a full queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_mispredicts <= 16'h0000;
      stat_full_stalls <= 16'h0000;
    end else begin
      if (misp_s && (stat_mispredicts != 16'hFFFF)) begin
        stat_mispredicts <= stat_mispredicts + 16'h0001;
      end
      if (br_dispatch_req && ckpt_full && (stat_full_stalls != 16'hFFFF)) begin
        stat_full_stalls <= stat_full_stalls + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_freelist_ckpt_ctrl.sv
// tb_freelist_ckpt_ctrl
//   Directed test bench for freelist_ckpt_ctrl.
//   Each expected value is worked out by hand for the stimulus vector that precedes it.
module tb_freelist_ckpt_ctrl;

  localparam int PTR_WIDTH = 8;
  localparam int NUM_CKPT  = 4;
  localparam int TAG_WIDTH = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 br_dispatch_req;
  logic [PTR_WIDTH-1:0] br_head_ptr;
  logic                 br_dispatch_gnt;
  logic [TAG_WIDTH-1:0] br_tag;
  logic                 ckpt_full;
  logic                 br_resolve_valid;
  logic [TAG_WIDTH-1:0] br_resolve_tag;
  logic                 br_resolve_mispredict;
  logic                 restore_valid;
  logic [PTR_WIDTH-1:0] restore_ptr;
  logic [NUM_CKPT-1:0]  squash_mask;
  logic [TAG_WIDTH:0]   ckpt_count;
`ifdef FLCKPT_STATS_EN
  logic [15:0]          stat_mispredicts;
  logic [15:0]          stat_full_stalls;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  freelist_ckpt_ctrl #(
    .PTR_WIDTH(PTR_WIDTH),
    .NUM_CKPT (NUM_CKPT),
    .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .br_dispatch_req      (br_dispatch_req),
    .br_head_ptr          (br_head_ptr),
    .br_dispatch_gnt      (br_dispatch_gnt),
    .br_tag               (br_tag),
    .ckpt_full            (ckpt_full),
    .br_resolve_valid     (br_resolve_valid),
    .br_resolve_tag       (br_resolve_tag),
    .br_resolve_mispredict(br_resolve_mispredict),
    .restore_valid        (restore_valid),
    .restore_ptr          (restore_ptr),
    .squash_mask          (squash_mask),
    .ckpt_count           (ckpt_count)
`ifdef FLCKPT_STATS_EN
    ,
    .stat_mispredicts     (stat_mispredicts),
    .stat_full_stalls     (stat_full_stalls)
`endif
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the active edge, then move 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_dispatch_req       = 1'b0;
    br_head_ptr           = 8'd0;
    br_resolve_valid      = 1'b0;
    br_resolve_tag        = 2'd0;
    br_resolve_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic resolve(input logic [1:0] tag, input logic misp);
    br_resolve_valid      = 1'b1;
    br_resolve_tag        = tag;
    br_resolve_mispredict = misp;
  endtask

  task automatic dispatch4(input int base);
    for (int i = 0; i < 4; i++) begin
      br_dispatch_req = 1'b1;
      br_head_ptr     = 8'(base + i);
      #1;
      check_eq("disp_gnt", 32'(br_dispatch_gnt), 32'd1);
      check_eq("disp_tag", 32'(br_tag), 32'(i));
      tick();
    end
    br_dispatch_req = 1'b0;
  endtask

  int exp_cnt5 [6] = '{1, 2, 2, 2, 3, 3};

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_count", 32'(ckpt_count), 32'd0);
    check_eq("rst_full", 32'(ckpt_full), 32'd0);
    check_eq("rst_rvalid", 32'(restore_valid), 32'd0);
    check_eq("rst_rptr", 32'(restore_ptr), 32'd0);
    check_eq("rst_mask", 32'(squash_mask), 32'd0);
    check_eq("rst_tag", 32'(br_tag), 32'd0);

    // 1: fill all four checkpoints; a fifth request is refused
    dispatch4(10);
    br_dispatch_req = 1'b1;
    br_head_ptr     = 8'd14;
    #1;
    check_eq("t1_full", 32'(ckpt_full), 32'd1);
    check_eq("t1_count", 32'(ckpt_count), 32'd4);
    check_eq("t1_gnt5", 32'(br_dispatch_gnt), 32'd0);
    tick();
    br_dispatch_req = 1'b0;
    check_eq("t1_count_hold", 32'(ckpt_count), 32'd4);

    // 2: out-of-order correct resolves, then in-order retirement
    resolve(2'd1, 1'b0);
    tick();
    resolve(2'd0, 1'b0);
    tick();
    idle_inputs();
    check_eq("t2_count4", 32'(ckpt_count), 32'd4);
    tick();
    check_eq("t2_count3", 32'(ckpt_count), 32'd3);
    check_eq("t2_notfull", 32'(ckpt_full), 32'd0);
    tick();
    check_eq("t2_count2", 32'(ckpt_count), 32'd2);
    tick();
    check_eq("t2_count2_hold", 32'(ckpt_count), 32'd2);

    // 3: mispredict tag 1 while tags 0 to 3 are live
    do_reset();
    dispatch4(10);
    resolve(2'd1, 1'b1);
    tick();
    idle_inputs();
    check_eq("t3_rvalid", 32'(restore_valid), 32'd1);
    check_eq("t3_rptr", 32'(restore_ptr), 32'd11);
    check_eq("t3_mask", 32'(squash_mask), 32'hE);
    check_eq("t3_count", 32'(ckpt_count), 32'd1);
    br_dispatch_req = 1'b1;
    br_head_ptr     = 8'd20;
    #1;
    check_eq("t3_gnt_recover", 32'(br_dispatch_gnt), 32'd0);
    tick();
    check_eq("t3_rvalid_drop", 32'(restore_valid), 32'd0);
    check_eq("t3_gnt_run", 32'(br_dispatch_gnt), 32'd1);
    check_eq("t3_next_tag", 32'(br_tag), 32'd1);
    tick();
    br_dispatch_req = 1'b0;
    check_eq("t3_count2", 32'(ckpt_count), 32'd2);

    // 4: a mispredict blocks a dispatch in the same cycle; resolves of squashed tags are ignored
    br_dispatch_req = 1'b1;
    br_head_ptr     = 8'd30;
    resolve(2'd1, 1'b1);
    #1;
    check_eq("t4_gnt_blocked", 32'(br_dispatch_gnt), 32'd0);
    tick();
    idle_inputs();
    check_eq("t4_rptr", 32'(restore_ptr), 32'd20);
    check_eq("t4_mask", 32'(squash_mask), 32'h2);
    check_eq("t4_count", 32'(ckpt_count), 32'd1);
    tick();
    resolve(2'd2, 1'b0);
    tick();
    idle_inputs();
    check_eq("t4_stale_count", 32'(ckpt_count), 32'd1);
    resolve(2'd2, 1'b1);
    tick();
    idle_inputs();
    check_eq("t4_stale_misp", 32'(restore_valid), 32'd0);
    check_eq("t4_stale_misp_cnt", 32'(ckpt_count), 32'd1);
    check_eq("t4_tag", 32'(br_tag), 32'd1);

    // 5: wrap around, then a mispredict whose squash range crosses index 3 to 0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      br_dispatch_req       = (k < 5);
      br_head_ptr           = 8'(40 + k);
      br_resolve_valid      = (k == 1 || k == 2);
      br_resolve_tag        = 2'(k - 1);
      br_resolve_mispredict = 1'b0;
      #1;
      if (k < 5) begin
        check_eq("t5_gnt", 32'(br_dispatch_gnt), 32'd1);
        check_eq("t5_tag", 32'(br_tag), 32'(k % 4));
      end
      tick();
      check_eq("t5_count", 32'(ckpt_count), 32'(exp_cnt5[k]));
    end
    idle_inputs();
    resolve(2'd3, 1'b1);
    tick();
    idle_inputs();
    check_eq("t5_rvalid", 32'(restore_valid), 32'd1);
    check_eq("t5_rptr", 32'(restore_ptr), 32'd43);
    check_eq("t5_mask", 32'(squash_mask), 32'h9);
    check_eq("t5_count_after", 32'(ckpt_count), 32'd1);
    tick();
    br_dispatch_req = 1'b1;
    br_head_ptr     = 8'd50;
    #1;
    check_eq("t5_gnt_after", 32'(br_dispatch_gnt), 32'd1);
    check_eq("t5_tag_after", 32'(br_tag), 32'd3);
    tick();
    br_head_ptr = 8'd51;
    tick();
    idle_inputs();
    check_eq("t5_count3", 32'(ckpt_count), 32'd3);
    // A younger mispredict is followed by an older one during RECOVER
    resolve(2'd0, 1'b1);
    tick();
    check_eq("t5_y_rptr", 32'(restore_ptr), 32'd51);
    check_eq("t5_y_mask", 32'(squash_mask), 32'h1);
    resolve(2'd2, 1'b1);
    tick();
    idle_inputs();
    check_eq("t5_o_rvalid", 32'(restore_valid), 32'd1);
    check_eq("t5_o_rptr", 32'(restore_ptr), 32'd42);
    check_eq("t5_o_mask", 32'(squash_mask), 32'hC);
    check_eq("t5_o_count", 32'(ckpt_count), 32'd0);
    tick();
    check_eq("t5_o_run", 32'(restore_valid), 32'd0);

    // 6: stall and mispredict statistics, then a reset while in RECOVER
    do_reset();
    dispatch4(60);
    br_dispatch_req = 1'b1;
    for (int s = 0; s < 3; s++) tick();
    idle_inputs();
    resolve(2'd3, 1'b1);
    tick();
    idle_inputs();
    check_eq("t6_m1_mask", 32'(squash_mask), 32'h8);
    check_eq("t6_m1_count", 32'(ckpt_count), 32'd3);
    tick();
    resolve(2'd2, 1'b1);
    tick();
    idle_inputs();
    check_eq("t6_m2_rvalid", 32'(restore_valid), 32'd1);
    check_eq("t6_m2_rptr", 32'(restore_ptr), 32'd62);
    check_eq("t6_m2_mask", 32'(squash_mask), 32'h4);
`ifdef FLCKPT_STATS_EN
    check_eq("t6_stat_misp", 32'(stat_mispredicts), 32'd2);
    check_eq("t6_stat_stall", 32'(stat_full_stalls), 32'd3);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_rst_rvalid", 32'(restore_valid), 32'd0);
    check_eq("t6_rst_count", 32'(ckpt_count), 32'd0);
    check_eq("t6_rst_mask", 32'(squash_mask), 32'd0);
    check_eq("t6_rst_rptr", 32'(restore_ptr), 32'd0);
    check_eq("t6_rst_tag", 32'(br_tag), 32'd0);
`ifdef FLCKPT_STATS_EN
    check_eq("t6_rst_stat_misp", 32'(stat_mispredicts), 32'd0);
    check_eq("t6_rst_stat_stall", 32'(stat_full_stalls), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
